// File: rtl/data_bridge_pkg.sv
// Shared types and helpers for the CPU data-port to sram-like bridge:
// FSM states, transfer size codes, byte-enable decode and kseg translation.
package data_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      W_ADDR,
      W_DATA,
      R_ADDR,
      R_DATA,
      R_DISCARD
   } bridge_state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef struct packed {
      logic       legal;
      logic [1:0] size;
      logic [1:0] offset;
   } be_map_t;

   // Only naturally aligned byte, halfword and word enables map to a transfer.
   function automatic be_map_t be_decode(input logic [3:0] wen);
      be_map_t m;
      m.legal  = 1'b1;
      m.size   = SIZE_BYTE;
      m.offset = 2'd0;
      case (wen)
         4'b1111: m.size = SIZE_WORD;
         4'b0011: m.size = SIZE_HALF;
         4'b1100: begin m.size = SIZE_HALF; m.offset = 2'd2; end
         4'b0001: m.offset = 2'd0;
         4'b0010: m.offset = 2'd1;
         4'b0100: m.offset = 2'd2;
         4'b1000: m.offset = 2'd3;
         default: m.legal = 1'b0;
      endcase
      return m;
   endfunction

   // kseg0/kseg1 fold onto physical memory; kseg2/kseg3 pass through.
   function automatic logic [31:0] kseg_xlate(input logic [31:0] a);
      return (a[31:30] == 2'b11) ? a : {3'b000, a[28:0]};
   endfunction

endpackage

// File: rtl/data_sram_bridge_if.sv
// sram-like data bus between the bridge (master) and the memory side (slave).
interface data_sram_bridge_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wdata;
   logic [DATA_W-1:0] data_rdata;
   logic              data_addr_ok;
   logic              data_data_ok;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_rdata, data_addr_ok, data_data_ok
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_rdata, data_addr_ok, data_data_ok
   );
endinterface

// File: rtl/wbuf_fifo.sv
// Synchronous store-buffer FIFO; a push while full succeeds when a pop
// happens in the same cycle.
module wbuf_fifo #(
   parameter int unsigned WIDTH = 66,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_W'(1);
         if (do_pop)  rptr <= rptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage carries no reset; entries are only read behind a valid count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end
endmodule

// File: rtl/data_sram_bridge.sv
// CPU data port to sram-like bus bridge with a posted store buffer;
// buffered stores drain ahead of loads, and flushed loads are retired silently.
module data_sram_bridge
   import data_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned WBUF_DEPTH = 4,
   parameter int unsigned KSEG_XLATE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   input  logic [DATA_W/8-1:0]   cpu_wen,
   input  logic                  cpu_ren,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_stall,
   output logic                  cpu_err,
   output logic                  wbuf_empty,
   data_sram_bridge_if.master    mem
);
   localparam int unsigned ENT_W = ADDR_W + 2 + DATA_W;
   localparam int unsigned CNT_W = $clog2(WBUF_DEPTH) + 1;
   localparam int unsigned XW    = (ADDR_W > 32) ? ADDR_W : 32;

   function automatic logic [ADDR_W-1:0] xlate(input logic [ADDR_W-1:0] a);
      logic [XW-1:0] e;
      e = XW'(a);
      if (KSEG_XLATE != 0) e[31:0] = kseg_xlate(e[31:0]);
      return ADDR_W'(e);
   endfunction

   bridge_state_t     state, state_nx;
   be_map_t           be;
   logic              wen_any, st_legal, st_block, illegal;
   logic              push, pop, rd_start, rd_cap, rd_done;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  count, count_nx;
   logic [ENT_W-1:0]  ent_in, head;
   logic              req_q, wr_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   assign be       = be_decode(4'(cpu_wen));
   assign wen_any  = |cpu_wen;
   assign illegal  = wen_any && (cpu_ren || !be.legal);
   assign st_legal = wen_any && !cpu_ren && be.legal;
   assign pop      = (state == W_DATA) && mem.data_data_ok;
   assign st_block = st_legal && fifo_full && !pop;
   assign push     = st_legal && !st_block;
   assign rd_start = cpu_ren && !rd_done && !flush;
   assign rd_cap   = (state == R_DATA) && mem.data_data_ok && !flush;
   assign count_nx = count + CNT_W'(push) - CNT_W'(pop);
   assign ent_in   = {xlate(cpu_addr + ADDR_W'(be.offset)), be.size, cpu_wdata};

   // A held load stalls until the cycle after its data returns (rd_done).
   assign cpu_stall = st_block || rd_start;

   wbuf_fifo #(.WIDTH(ENT_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (ent_in),
      .pop   (pop),
      .rdata (head),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (!fifo_empty)   state_nx = W_ADDR;
            else if (rd_start) state_nx = R_ADDR;
         end
         W_ADDR:    if (mem.data_addr_ok) state_nx = W_DATA;
         W_DATA:    if (mem.data_data_ok) state_nx = IDLE;
         R_ADDR: begin
            if (mem.data_addr_ok) state_nx = flush ? R_DISCARD : R_DATA;
            else if (flush)       state_nx = IDLE;
         end
         // Data arriving with the flush closes the read; no second data_ok follows.
         R_DATA: begin
            if (mem.data_data_ok) state_nx = IDLE;
            else if (flush)       state_nx = R_DISCARD;
         end
         R_DISCARD: if (mem.data_data_ok) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // Request fields are latched on entry to an address phase and held stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q      <= 1'b0;
         wr_q       <= 1'b0;
         size_q     <= 2'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cpu_rdata  <= '0;
         cpu_err    <= 1'b0;
         rd_done    <= 1'b0;
         wbuf_empty <= 1'b1;
      end else begin
         req_q      <= (state_nx == W_ADDR) || (state_nx == R_ADDR);
         cpu_err    <= illegal && !cpu_stall;
         rd_done    <= rd_cap;
         wbuf_empty <= (count_nx == '0) && (state_nx != W_ADDR) && (state_nx != W_DATA);
         if (rd_cap) cpu_rdata <= mem.data_rdata;
         if (state == IDLE && state_nx == W_ADDR) begin
            wr_q    <= 1'b1;
            addr_q  <= head[ENT_W-1 -: ADDR_W];
            size_q  <= head[DATA_W +: 2];
            wdata_q <= head[DATA_W-1:0];
         end else if (state == IDLE && state_nx == R_ADDR) begin
            wr_q    <= 1'b0;
            addr_q  <= xlate(cpu_addr);
            size_q  <= SIZE_WORD;
            wdata_q <= '0;
         end
      end
   end

   assign mem.data_req   = req_q;
   assign mem.data_wr    = wr_q;
   assign mem.data_size  = size_q;
   assign mem.data_addr  = addr_q;
   assign mem.data_wdata = wdata_q;
endmodule

// File: doc/data_sram_bridge.md
DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width (≥30).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width (only 32 legal this generation).
REQ-003 SHALL have parameter WBUF_DEPTH, default 4, meaning store-buffer entries (power of two, 2..16).
REQ-004 SHALL have parameter KSEG_XLATE, default 1, meaning enable fixed kseg0/kseg1 physical translation.
REQ-005 SHALL have ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-006 SHALL have CPU-side ports: flush input 1 pipeline flush; cpu_addr input ADDR_W; cpu_wdata input DATA_W; cpu_wen input DATA_W/8 byte enables; cpu_ren input 1 load request.
REQ-007 SHALL have CPU-side ports: cpu_rdata output DATA_W load data; cpu_stall output 1 hold pipeline; cpu_err output 1 illegal-access pulse; wbuf_empty output 1 store buffer empty.
REQ-008 SHALL have sram-like ports: data_req output 1; data_wr output 1; data_size output 2; data_addr output ADDR_W; data_wdata output DATA_W; data_rdata input DATA_W; data_addr_ok input 1; data_data_ok input 1.

Function
REQ-009 Address mapping SHALL be: KSEG_XLATE=1 and addr[31:30]!=2'b11 -> top 3 bits cleared; otherwise unchanged.
REQ-010 Byte-enable mapping SHALL be: 1111 -> size 2, offset 0; 0011/1100 -> size 1, offset 0/2; 0001/0010/0100/1000 -> size 0, offset 0/1/2/3; data_addr = translate(cpu_addr + offset); data_wdata = cpu_wdata unshifted.
REQ-011 Any other nonzero cpu_wen, or cpu_ren with nonzero cpu_wen, SHALL pulse cpu_err one cycle; illegal store dropped; simultaneous ren+wen served as read only.
REQ-012 A legal store SHALL enqueue {addr,size,wdata} in the cycle it is presented with cpu_stall=0; no stall while buffer not full.
REQ-013 Buffer full SHALL assert cpu_stall combinationally for a presented store; store held by CPU, enqueued on first cycle a slot is free; pop and push in same cycle when full SHALL both succeed.
REQ-014 FSM states SHALL be IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA, R_DISCARD.
REQ-015 IDLE: buffer non-empty -> W_ADDR (drain has priority over reads); else cpu_ren -> R_ADDR; else stay.
REQ-016 W_ADDR/R_ADDR SHALL drive data_req=1 with data_wr/size/addr/wdata registered and stable until data_addr_ok; addr_ok -> W_DATA/R_DATA, data_req low next cycle.
REQ-017 W_DATA: data_data_ok -> pop head entry, go IDLE.
REQ-018 Load SHALL stall (cpu_stall=1) from presentation until the cycle after its data_data_ok; cpu_rdata SHALL register data_rdata on that data_ok and hold until next load completes; min latency with empty buffer, addr_ok and data_ok each in first cycle: 3 cycles stall.
REQ-019 flush in R_ADDR before/without addr_ok SHALL drop data_req next cycle, go IDLE, release stall.
REQ-020 flush in R_DATA, or in R_ADDR coincident with addr_ok, SHALL go R_DISCARD and release stall; R_DISCARD consumes data_data_ok without updating cpu_rdata, then IDLE.
REQ-021 flush SHALL never discard buffered stores or an in-flight write.
REQ-022 While cpu_ren presented and FSM not ready for it (draining, R_DISCARD), cpu_stall SHALL remain 1.
REQ-023 wbuf_empty SHALL be 1 iff buffer count 0 and FSM not in W_ADDR/W_DATA.

Reset
REQ-024 rst SHALL set FSM IDLE, buffer pointers/count 0, data_req/data_wr 0, data_size/addr/wdata 0, cpu_rdata 0, cpu_err 0, wbuf_empty 1.
REQ-025 rst mid-transaction SHALL abandon it without waiting for data_ok; downstream is reset together.
REQ-026 cpu_stall SHALL be 0 in reset.

Structure
REQ-027 State encodings, size codes and the translate function SHALL live in shared package data_bridge_pkg.
REQ-028 The store buffer SHALL be sub-module wbuf_fifo (sync FIFO, WBUF_DEPTH, count output, same-cycle push/pop when full).

Verification
REQ-029 Store word 0x11223344 to 0x80001000, addr_ok/data_ok immediate -> no stall; req with wr=1 size=2 addr=0x00001000.
REQ-030 Store byte wen=0100 to 0xBFC00008 -> size=0 addr=0x1FC0000A wdata unchanged; wen=0101 -> cpu_err pulse, no request.
REQ-031 Five stores back-to-back, WBUF_DEPTH=4, addr_ok held low -> stall on fifth only; released when first write completes.
REQ-032 Store to 0x80000000 then load 0x80000000, data_ok delay 2 -> write request precedes read; cpu_rdata=data_rdata after data_ok.
REQ-033 Load accepted (addr_ok) then flush -> stall drops next cycle; data_ok 4 cycles later with 0xDEADBEEF -> cpu_rdata unchanged; next load served normally.
REQ-034 rst asserted in W_DATA with 3 entries -> next cycle wbuf_empty=1, data_req=0, FSM IDLE.
